// File: rtl/pulse_train_gen_if.sv
// Control-side bundle for the pulse-train generator.
// master drives requests and config; slave is the generator.
interface pulse_train_gen_if #(
  parameter int COUNT_WIDTH = 8,
  parameter int PHASE_WIDTH = 8
);
  logic                   start;
  logic [COUNT_WIDTH-1:0] pulseCount;
  logic [PHASE_WIDTH-1:0] highCycles;
  logic [PHASE_WIDTH-1:0] lowCycles;
  logic                   abort;
  logic                   pulseOut;
  logic                   busy;
  logic                   done;
  logic [COUNT_WIDTH-1:0] pulsesSent;

  modport master (
    output start, pulseCount, highCycles,
    output lowCycles, abort,
    input  pulseOut, busy, done, pulsesSent
  );

  modport slave (
    input  start, pulseCount, highCycles,
    input  lowCycles, abort,
    output pulseOut, busy, done, pulsesSent
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Pulse-train generator: N pulses of Heff high / Leff low cycles,
// registered outputs, one-cycle done strobe, abort and async reset.
module pulse_train_gen #(
  parameter int COUNT_WIDTH = 8,
  parameter int PHASE_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  pulse_train_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  state_e state_q, state_d;

  logic [PHASE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PHASE_WIDTH-1:0] hi_q, hi_d;
  logic [PHASE_WIDTH-1:0] lo_q, lo_d;
  logic [COUNT_WIDTH-1:0] n_q, n_d;
  logic [COUNT_WIDTH-1:0] sent_q, sent_d;
  logic pulse_q, pulse_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic                   accept;
  logic                   phase_end;
  logic                   last;
  logic [PHASE_WIDTH-1:0] heff;
  logic [PHASE_WIDTH-1:0] leff;
  logic [COUNT_WIDTH-1:0] sent_inc;

  assign accept    = (state_q == IDLE) & bus.start & ~bus.abort;
  assign phase_end = (cnt_q == '0);
  assign sent_inc  = sent_q + COUNT_WIDTH'(1);
  assign last      = (sent_inc == n_q);

  // zero-length phases run as one cycle
  assign heff = (bus.highCycles == '0) ?
                PHASE_WIDTH'(1) : bus.highCycles;
  assign leff = (bus.lowCycles == '0) ?
                PHASE_WIDTH'(1) : bus.lowCycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      n_q     <= '0;
      sent_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      n_q     <= n_d;
      sent_q  <= sent_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    n_d     = n_q;
    sent_d  = sent_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sent_d = '0;
          if (bus.pulseCount != '0) begin
            state_d = HIGH;
            n_d     = bus.pulseCount;
            hi_d    = heff;
            lo_d    = leff;
            cnt_d   = heff - PHASE_WIDTH'(1);
          end
        end
      end
      HIGH: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (phase_end) begin
          sent_d = sent_inc;
          if (last) begin
            state_d = IDLE;
          end else begin
            state_d = LOW;
            cnt_d   = lo_q - PHASE_WIDTH'(1);
          end
        end else begin
          cnt_d = cnt_q - PHASE_WIDTH'(1);
        end
      end
      LOW: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (phase_end) begin
          state_d = HIGH;
          cnt_d   = hi_q - PHASE_WIDTH'(1);
        end else begin
          cnt_d = cnt_q - PHASE_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs are registered copies of the upcoming state
  always_comb begin
    pulse_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_d == HIGH): begin
        pulse_d = 1'b1;
        busy_d  = 1'b1;
      end
      (state_d == LOW): busy_d = 1'b1;
      default: begin
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    done_d = (accept & (bus.pulseCount == '0)) |
             ((state_q == HIGH) & ~bus.abort &
              phase_end & last);
  end

  assign bus.pulseOut   = pulse_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pulsesSent = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed plus random stimulus
// against a closed-form model of the pulse-train timing.
module tb_pulse_train_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pulse_train_gen_if #(
    .COUNT_WIDTH(8),
    .PHASE_WIDTH(8)
  ) bus ();

  pulse_train_gen #(
    .COUNT_WIDTH(8),
    .PHASE_WIDTH(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // model: train accepted at m_t, aborted at m_a (-1 if none)
  int m_t = -1;
  int m_n = 0;
  int m_he = 1;
  int m_le = 1;
  int m_a = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               tag, cyc, got, exp);
    end
  endtask

  function automatic void model(input int c, output int p,
                                output int b, output int d,
                                output int s);
    int cc, r, per, dd;
    p = 0;
    b = 0;
    d = 0;
    s = 0;
    if (m_t < 0) return;
    if (m_n == 0) begin
      d = (c == m_t + 1) ? 1 : 0;
      return;
    end
    dd  = m_t + m_n * m_he + (m_n - 1) * m_le + 1;
    per = m_he + m_le;
    cc  = (m_a >= 0 && c > m_a) ? m_a : c;
    if (cc >= dd) begin
      s = m_n;
      d = (c == dd) ? 1 : 0;
      return;
    end
    r = cc - m_t - 1;
    s = r / per + (((r % per) >= m_he) ? 1 : 0);
    if (cc == c) begin
      p = ((r % per) < m_he) ? 1 : 0;
      b = 1;
    end
  endfunction

  task automatic step(input bit st, input int n, input int h,
                      input int l, input bit ab);
    int p, b, d, s;
    @(negedge clk);
    bus.start      = st;
    bus.pulseCount = n[7:0];
    bus.highCycles = h[7:0];
    bus.lowCycles  = l[7:0];
    bus.abort      = ab;
    model(cyc, p, b, d, s);
    if (ab && b == 1) begin
      m_a = cyc;
    end else if (st && !ab && b == 0) begin
      m_t  = cyc;
      m_n  = n;
      m_he = (h == 0) ? 1 : h;
      m_le = (l == 0) ? 1 : l;
      m_a  = -1;
    end
    @(posedge clk);
    #1;
    model(cyc, p, b, d, s);
    chk("pulseOut", int'(bus.pulseOut), p);
    chk("busy", int'(bus.busy), b);
    chk("done", int'(bus.done), d);
    chk("pulsesSent", int'(bus.pulsesSent), s);
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pulseOut"}, int'(bus.pulseOut), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_pulsesSent"}, int'(bus.pulsesSent), 0);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.pulseCount = '0;
    bus.highCycles = '0;
    bus.lowCycles  = '0;
    bus.abort      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 3, 2, 1, 1'b0);
    idle(12);

    step(1'b1, 2, 0, 0, 1'b0);
    idle(6);
    step(1'b1, 0, 5, 5, 1'b0);
    idle(3);

    step(1'b1, 4, 3, 2, 1'b0);
    idle(6);
    step(1'b0, 0, 0, 0, 1'b1);
    idle(14);
    step(1'b1, 3, 1, 1, 1'b1);
    idle(3);

    step(1'b1, 2, 2, 2, 1'b0);
    idle(2);
    step(1'b1, 7, 9, 9, 1'b0);
    idle(6);

    step(1'b1, 1, 1, 1, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0);
    step(1'b1, 1, 2, 5, 1'b0);
    idle(4);

    step(1'b1, 2, 255, 255, 1'b0);
    idle(770);

    step(1'b1, 3, 5, 1, 1'b0);
    idle(2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_t = -1;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);

    repeat (2500) begin
      step($urandom_range(0, 2) == 0,
           int'($urandom_range(0, 5)),
           int'($urandom_range(0, 4)),
           int'($urandom_range(0, 4)),
           $urandom_range(0, 24) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
